// File: rtl/csr_file.sv
// Machine-mode CSR storage and trap control.
// Holds mstatus/mie/mip/mepc and the 64-bit cycle/instret counters, supplies the
// current CSR value to the CSR ALU, commits its masked result, and sequences
// interrupt entry and mret return for the fetch stage.
module csr_file #(
    parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic        stall,
    input  logic        retire,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    input  logic        wfi,
    output logic        trap_taken,
    output logic [31:0] redirect_pc,
    output logic        wfi_stall
);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMie       = 12'h304;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMip       = 12'h344;
    localparam logic [11:0] AddrMcycle    = 12'hC00;
    localparam logic [11:0] AddrMcycleh   = 12'hC80;
    localparam logic [11:0] AddrMinstret  = 12'hC02;
    localparam logic [11:0] AddrMinstreth = 12'hC82;

    // mstatus fields
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [1:0]  mstatus_mpp_q,  mstatus_mpp_d;
    // mie fields
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    // mip fields (registered copies of the interrupt lines)
    logic        mip_mtip_q, mip_mtip_d;
    logic        mip_meip_q, mip_meip_d;

    logic [31:0] mepc_q,     mepc_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        irq_pend;
    logic        mret_commit;
    logic        write_commit;
    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;

    // Interrupt decision, redirect target and wfi hold.
    always_comb begin
        irq_pend     = (mie_meie_q & mip_meip_q) | (mie_mtie_q & mip_mtip_q);
        trap_taken   = mstatus_mie_q & irq_pend & ~stall;
        // Lower-priority actions are dropped: their instruction is flushed.
        mret_commit  = mret & ~stall & ~trap_taken;
        write_commit = csr_we & ~stall & ~trap_taken & ~mret_commit;
        redirect_pc  = trap_taken ? MTVEC_BASE : mepc_q;
        // Ignores mstatus.MIE so an enabled-but-globally-masked interrupt still wakes.
        wfi_stall    = wfi & ~irq_pend;
    end

    // Assemble architectural register views; unimplemented bits read 0.
    always_comb begin
        mstatus_val        = 32'h0;
        mstatus_val[3]     = mstatus_mie_q;
        mstatus_val[7]     = mstatus_mpie_q;
        mstatus_val[12:11] = mstatus_mpp_q;

        mie_val            = 32'h0;
        mie_val[7]         = mie_mtie_q;
        mie_val[11]        = mie_meie_q;

        mip_val            = 32'h0;
        mip_val[7]         = mip_mtip_q;
        mip_val[11]        = mip_meip_q;
    end

    // Combinational read mux feeding the CSR ALU src1 operand.
    always_comb begin
        case (csr_addr)
            AddrMstatus:   csr_rdata = mstatus_val;
            AddrMie:       csr_rdata = mie_val;
            AddrMtvec:     csr_rdata = MTVEC_BASE;
            AddrMepc:      csr_rdata = mepc_q;
            AddrMip:       csr_rdata = mip_val;
            AddrMcycle:    csr_rdata = mcycle_q[31:0];
            AddrMcycleh:   csr_rdata = mcycle_q[63:32];
            AddrMinstret:  csr_rdata = minstret_q[31:0];
            AddrMinstreth: csr_rdata = minstret_q[63:32];
            default:       csr_rdata = 32'h0;
        endcase
    end

    // Next-state: trap entry, then mret, then software write; counters and mip always.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mstatus_mpp_d  = mstatus_mpp_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mepc_d         = mepc_q;

        if (trap_taken) begin
            mepc_d         = trap_pc;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mstatus_mpp_d  = 2'b11;
        end else if (mret_commit) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            mstatus_mpp_d  = 2'b11;
        end else if (write_commit) begin
            case (csr_addr)
                AddrMstatus: begin
                    mstatus_mie_d  = csr_wdata[3];
                    mstatus_mpie_d = csr_wdata[7];
                    mstatus_mpp_d  = csr_wdata[12:11];
                end
                AddrMie: begin
                    mie_mtie_d = csr_wdata[7];
                    mie_meie_d = csr_wdata[11];
                end
                AddrMepc: mepc_d = csr_wdata;
                default: ;
            endcase
        end

        // Sampled regardless of stall: one cycle of registration on the irq lines.
        mip_meip_d = irq_ext;
        mip_mtip_d = irq_timer;

        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = (retire && !stall) ? minstret_q + 64'd1 : minstret_q;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mstatus_mpp_q  <= 2'b00;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mepc_q         <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mstatus_mpp_q  <= mstatus_mpp_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mip_mtip_q     <= mip_mtip_d;
            mip_meip_q     <= mip_meip_d;
            mepc_q         <= mepc_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table-driven reset/readback vectors,
// directed trap/mret/wfi/counter sequences, and a randomized run against a
// word-level reference model.
module tb_csr_file;

    localparam logic [31:0] MTVEC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_rdata;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic        stall = 1'b0;
    logic        retire = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic        mret = 1'b0;
    logic        wfi = 1'b0;
    logic        trap_taken;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    int n_checks = 0;
    int n_fail   = 0;

    csr_file #(.MTVEC_BASE(MTVEC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_addr    (csr_addr),
        .csr_rdata   (csr_rdata),
        .csr_we      (csr_we),
        .csr_wdata   (csr_wdata),
        .stall       (stall),
        .retire      (retire),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .trap_pc     (trap_pc),
        .mret        (mret),
        .wfi         (wfi),
        .trap_taken  (trap_taken),
        .redirect_pc (redirect_pc),
        .wfi_stall   (wfi_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Advance from the low phase through a rising edge to the next low phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_we    = 1'b1;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t rst_tab[11];
    vec_t wr_tab[12];

    // Reference model: architectural CSRs as whole words and 64-bit integers.
    logic [31:0] m_mstatus, m_mie, m_mip, m_mepc;
    logic [63:0] m_cycle, m_instret;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return MTVEC;
            12'h341: return m_mepc;
            12'h344: return m_mip;
            12'hC00: return m_cycle[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC02: return m_instret[31:0];
            12'hC82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [11:0] addr_pool[10];
        logic        m_pend, m_trap;

        rst_tab[0]  = '{12'h300, 1'b0, 32'h0, 32'h0};
        rst_tab[1]  = '{12'h304, 1'b0, 32'h0, 32'h0};
        rst_tab[2]  = '{12'h305, 1'b0, 32'h0, MTVEC};
        rst_tab[3]  = '{12'h341, 1'b0, 32'h0, 32'h0};
        rst_tab[4]  = '{12'h344, 1'b0, 32'h0, 32'h0};
        rst_tab[5]  = '{12'hC00, 1'b0, 32'h0, 32'h0};
        rst_tab[6]  = '{12'hC80, 1'b0, 32'h0, 32'h0};
        rst_tab[7]  = '{12'hC02, 1'b0, 32'h0, 32'h0};
        rst_tab[8]  = '{12'hC82, 1'b0, 32'h0, 32'h0};
        rst_tab[9]  = '{12'h7C0, 1'b0, 32'h0, 32'h0};
        rst_tab[10] = '{12'hF14, 1'b0, 32'h0, 32'h0};

        wr_tab[0]  = '{12'h300, 1'b1, 32'hFFFF_FFFF, 32'h0000_1888};
        wr_tab[1]  = '{12'h304, 1'b1, 32'hFFFF_FFFF, 32'h0000_0880};
        wr_tab[2]  = '{12'h305, 1'b1, 32'h0000_0000, MTVEC};
        wr_tab[3]  = '{12'h341, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        wr_tab[4]  = '{12'h341, 1'b1, 32'h0000_0003, 32'h0000_0003};
        wr_tab[5]  = '{12'h344, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        wr_tab[6]  = '{12'h7C0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        wr_tab[7]  = '{12'hC02, 1'b1, 32'h0000_1234, 32'h0000_0000};
        wr_tab[8]  = '{12'hC82, 1'b1, 32'h0000_1234, 32'h0000_0000};
        wr_tab[9]  = '{12'h300, 1'b1, 32'h0000_0000, 32'h0000_0000};
        wr_tab[10] = '{12'h304, 1'b1, 32'h0000_0080, 32'h0000_0080};
        wr_tab[11] = '{12'h304, 1'b1, 32'h0000_0000, 32'h0000_0000};

        addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344,
                      12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0};

        // Reads while reset is held, then mcycle one cycle after release.
        @(negedge clk);
        for (int i = 0; i < 11; i++) read_check("reset_read", rst_tab[i].addr, rst_tab[i].exp);
        #1;
        check("reset_trap_taken", {31'h0, trap_taken}, 32'h0);
        check("reset_wfi_stall", {31'h0, wfi_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read_check("mcycle_after_reset", 12'hC00, 32'h1);

        // Write then read back next cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            csr_write(wr_tab[i].addr, wr_tab[i].wdata);
            read_check("write_readback", wr_tab[i].addr, wr_tab[i].exp);
        end

        // Interrupt entry and mret return.
        do_reset();
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        irq_ext = 1'b1;
        trap_pc = 32'h0000_0400;
        #1;
        check("trap_before_mip", {31'h0, trap_taken}, 32'h0);
        tick();
        #1;
        check("trap_taken", {31'h0, trap_taken}, 32'h1);
        check("trap_redirect", redirect_pc, MTVEC);
        irq_ext = 1'b0;
        tick();
        read_check("trap_mepc", 12'h341, 32'h0000_0400);
        read_check("trap_mstatus", 12'h300, 32'h0000_1880);
        check("trap_deasserted", {31'h0, trap_taken}, 32'h0);
        mret = 1'b1;
        #1;
        check("mret_redirect", redirect_pc, 32'h0000_0400);
        tick();
        mret = 1'b0;
        read_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // Trap, mret and mepc write in one cycle: trap wins.
        irq_ext = 1'b1;
        tick();
        csr_addr  = 12'h341;
        csr_we    = 1'b1;
        csr_wdata = 32'h0000_1234;
        mret      = 1'b1;
        trap_pc   = 32'h0000_0888;
        #1;
        check("simul_trap_taken", {31'h0, trap_taken}, 32'h1);
        tick();
        csr_we = 1'b0;
        mret   = 1'b0;
        read_check("simul_mepc", 12'h341, 32'h0000_0888);
        read_check("simul_mstatus", 12'h300, 32'h0000_1880);

        // Setting MIE with a pending enabled interrupt traps the following cycle.
        #1;
        check("mie_clear_no_trap", {31'h0, trap_taken}, 32'h0);
        csr_write(12'h300, 32'h8);
        #1;
        check("mie_set_trap", {31'h0, trap_taken}, 32'h1);
        irq_ext = 1'b0;
        tick();

        // minstret carry from low into high word; stalled retire does not count.
        force dut.minstret_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.minstret_q;
        read_check("instret_preset", 12'hC02, 32'hFFFF_FFFF);
        retire = 1'b1;
        stall  = 1'b1;
        tick();
        stall  = 1'b0;
        retire = 1'b0;
        read_check("instret_stalled", 12'hC02, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        read_check("instret_wrap_lo", 12'hC02, 32'h0);
        read_check("instret_wrap_hi", 12'hC82, 32'h1);

        // wfi wakes on an enabled interrupt even with MIE clear.
        do_reset();
        csr_write(12'h304, 32'h80);
        wfi = 1'b1;
        #1;
        check("wfi_stall_set", {31'h0, wfi_stall}, 32'h1);
        irq_timer = 1'b1;
        #1;
        check("wfi_stall_hold", {31'h0, wfi_stall}, 32'h1);
        tick();
        #1;
        check("wfi_stall_wake", {31'h0, wfi_stall}, 32'h0);
        check("wfi_no_trap", {31'h0, trap_taken}, 32'h0);
        wfi       = 1'b0;
        irq_timer = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        m_mstatus = 32'h0; m_mie = 32'h0; m_mip = 32'h0; m_mepc = 32'h0;
        m_cycle   = 64'h0; m_instret = 64'h0;
        for (int c = 0; c < 2000; c++) begin
            csr_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 9)];
            csr_we    = ($urandom_range(0, 2) == 0);
            csr_wdata = $urandom;
            stall     = ($urandom_range(0, 3) == 0);
            retire    = ($urandom_range(0, 1) == 0);
            irq_ext   = ($urandom_range(0, 3) == 0);
            irq_timer = ($urandom_range(0, 3) == 0);
            mret      = ($urandom_range(0, 7) == 0);
            wfi       = ($urandom_range(0, 3) == 0);
            trap_pc   = $urandom & 32'hFFFF_FFFC;
            #1;
            m_pend = ((m_mie & m_mip) != 32'h0);
            m_trap = m_mstatus[3] && m_pend && !stall;
            check("rand_rdata", csr_rdata, model_read(csr_addr));
            check("rand_trap_taken", {31'h0, trap_taken}, {31'h0, m_trap});
            check("rand_redirect", redirect_pc, m_trap ? MTVEC : m_mepc);
            check("rand_wfi_stall", {31'h0, wfi_stall}, {31'h0, wfi && !m_pend});
            if (m_trap) begin
                m_mepc    = trap_pc;
                m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            end else if (mret && !stall) begin
                m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (csr_we && !stall) begin
                if (csr_addr == 12'h300) m_mstatus = csr_wdata & 32'h1888;
                if (csr_addr == 12'h304) m_mie     = csr_wdata & 32'h0880;
                if (csr_addr == 12'h341) m_mepc    = csr_wdata;
            end
            m_mip   = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
            m_cycle = m_cycle + 1;
            if (retire && !stall) m_instret = m_instret + 1;
            tick();
        end

        // Asynchronous reset in the middle of the high phase.
        csr_we = 1'b0; mret = 1'b0; stall = 1'b0; retire = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0;
        wfi      = 1'b1;
        csr_addr = 12'hC00;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mcycle", csr_rdata, 32'h0);
        check("async_rst_trap", {31'h0, trap_taken}, 32'h0);
        check("async_rst_wfi_stall", {31'h0, wfi_stall}, 32'h1);
        read_check("async_rst_mstatus", 12'h300, 32'h0);
        wfi = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
